// File: rtl/seq_mul_param.sv
// Parametrised shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with early exit.
// Optional signed operation is compiled in with `define MUL_SIGNED_EN.
module seq_mul_param #(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 LOAD,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef MUL_SIGNED_EN
    input  logic                 SIGNED_OP,
`endif
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   RESULT,
    output logic [WIDTH-1:0]     P
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mc;
    logic [WIDTH-1:0]     mp;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic [2*WIDTH-1:0]   result_q;

    logic                 accept;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 sign_in;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mp_shift;
    logic                 last_step;

    // Negation of the magnitude product; zero stays zero under two's complement.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

`ifdef MUL_SIGNED_EN
    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic en, input logic [WIDTH-1:0] v);
        return (en && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    assign a_mag   = magnitude(SIGNED_OP, A);
    assign b_mag   = magnitude(SIGNED_OP, B);
    assign sign_in = SIGNED_OP & (A[WIDTH-1] ^ B[WIDTH-1]);
`else
    assign a_mag   = A;
    assign b_mag   = B;
    assign sign_in = 1'b0;
`endif

    assign accept    = LOAD && (state == S_IDLE || state == S_DONE);
    assign acc_sum   = acc + (mp[0] ? mc : '0);
    assign mp_shift  = mp >> 1;
    assign last_step = (mp_shift == '0) || (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (LOAD) state_nxt = (b_mag != '0) ? S_RUN : S_DONE;
                else      state_nxt = S_IDLE;
            end
            S_RUN:   if (last_step) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mc       <= '0;
            mp       <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            mc  <= {{WIDTH{1'b0}}, a_mag};
            mp  <= b_mag;
            acc <= '0;
            cnt <= '0;
            neg <= sign_in;
            if (b_mag == '0) result_q <= '0;
        end else if (state == S_RUN) begin
            acc <= acc_sum;
            mc  <= mc << 1;
            mp  <= mp_shift;
            cnt <= cnt + CNT_W'(1);
            if (last_step) result_q <= apply_sign(neg, acc_sum);
        end
    end

    assign BUSY   = (state == S_RUN);
    assign DONE   = (state == S_DONE);
    assign RESULT = result_q;
    assign P      = result_q[WIDTH-1:0];

endmodule

// File: tb/tb_seq_mul_param.sv
// Directed and randomized bench for seq_mul_param against an arithmetic reference model.
// Signed cases are included when MUL_SIGNED_EN is defined.
module tb_seq_mul_param;

    localparam int W = 16;

    logic            CLK = 1'b0;
    logic            RESET, LOAD;
    logic [W-1:0]    A, B;
    logic            BUSY, DONE;
    logic [2*W-1:0]  RESULT;
    logic [W-1:0]    P;

    logic            LOAD8;
    logic [7:0]      A8, B8;
    logic            BUSY8, DONE8;
    logic [15:0]     RESULT8;
    logic [7:0]      P8;

`ifdef MUL_SIGNED_EN
    logic            SIGNED_OP;
    logic            SIGNED_OP8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    seq_mul_param #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .A(A), .B(B),
`ifdef MUL_SIGNED_EN
        .SIGNED_OP(SIGNED_OP),
`endif
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .P(P)
    );

    seq_mul_param #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .LOAD(LOAD8), .A(A8), .B(B8),
`ifdef MUL_SIGNED_EN
        .SIGNED_OP(SIGNED_OP8),
`endif
        .BUSY(BUSY8), .DONE(DONE8), .RESULT(RESULT8), .P(P8)
    );

    // Reference: true integer product truncated to 2*w bits.
    function automatic logic [63:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                             input bit sgn, input int w);
        longint sa, sb, pr;
        logic [63:0] mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        pr = sa * sb;
        mask = (2*w >= 64) ? '1 : ((64'd1 << (2*w)) - 64'd1);
        return 64'(pr) & mask;
    endfunction

    // Reference latency: position of the highest set bit of |B|, plus one.
    function automatic int ref_k(input logic [63:0] b, input bit sgn, input int w);
        logic [63:0] mag;
        int k;
        mag = b;
        if (sgn && b[w-1]) mag = (64'd1 << w) - b;
        k = 0;
        for (int i = 0; i < w; i++) if (mag[i]) k = i + 1;
        return k;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation starting from IDLE/DONE at a falling edge; ends one cycle after DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                          input string tag);
        logic [63:0] exp;
        int busy_cnt;
        exp = ref_prod(64'(a), 64'(b), sgn, W);
        LOAD = 1'b1; A = a; B = b;
`ifdef MUL_SIGNED_EN
        SIGNED_OP = sgn;
`endif
        @(negedge CLK);
        LOAD = 1'b0; A = W'($urandom); B = W'($urandom);
        busy_cnt = 0;
        while (BUSY === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            @(negedge CLK);
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(ref_k(64'(b), sgn, W)));
        check({tag, "_done"}, 64'(DONE), 64'd1);
        check({tag, "_result"}, 64'(RESULT), exp);
        check({tag, "_p"}, 64'(P), 64'(exp[W-1:0]));
        @(negedge CLK);
        check({tag, "_done_pulse"}, 64'(DONE), 64'd0);
        check({tag, "_hold"}, 64'(RESULT), exp);
    endtask

    initial begin
        int g;
        int busy8;
        bit seen_done;
        logic [31:0] ra, rb;
        bit rsgn;

        RESET = 1'b1; LOAD = 1'b0; A = '0; B = '0;
        LOAD8 = 1'b0; A8 = '0; B8 = '0;
`ifdef MUL_SIGNED_EN
        SIGNED_OP = 1'b0; SIGNED_OP8 = 1'b0;
`endif
        @(negedge CLK);
        @(negedge CLK);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_result", 64'(RESULT), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        run_op(16'h0003, 16'h0005, 1'b0, "basic");
        for (int i = 0; i < 10; i++) @(negedge CLK);
        check("idle_hold", 64'(RESULT), 64'h0000000F);
        check("idle_done", 64'(DONE), 64'd0);

        run_op(16'hFFFF, 16'hFFFF, 1'b0, "max16");

        LOAD8 = 1'b1; A8 = 8'hFF; B8 = 8'hFF;
        @(negedge CLK);
        LOAD8 = 1'b0;
        busy8 = 0;
        while (BUSY8 === 1'b1 && busy8 < 100) begin
            busy8++;
            @(negedge CLK);
        end
        check("max8_busy_cycles", 64'(busy8), 64'(ref_k(64'hFF, 1'b0, 8)));
        check("max8_done", 64'(DONE8), 64'd1);
        check("max8_result", 64'(RESULT8), ref_prod(64'hFF, 64'hFF, 1'b0, 8));
        check("max8_p", 64'(P8), 64'h01);
        @(negedge CLK);

        run_op(16'h1234, 16'h0000, 1'b0, "b_zero");
        run_op(16'h1234, 16'h8000, 1'b0, "b_msb");

        // LOAD during RUN must be ignored.
        LOAD = 1'b1; A = 16'd7; B = 16'd9;
        @(negedge CLK);
        A = 16'd2; B = 16'd2;
        @(negedge CLK);
        @(negedge CLK);
        LOAD = 1'b0;
        g = 0;
        while (DONE !== 1'b1 && g < 100) begin g++; @(negedge CLK); end
        check("ignore_load_timeout", 64'(g < 100), 64'd1);
        check("ignore_load_result", 64'(RESULT), ref_prod(64'd7, 64'd9, 1'b0, W));
        @(negedge CLK);

        // Reset in the fourth RUN cycle aborts with no later DONE.
        LOAD = 1'b1; A = 16'd5; B = 16'hF0F0;
        @(negedge CLK);
        LOAD = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        check("abort_running", 64'(BUSY), 64'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_done", 64'(DONE), 64'd0);
        check("abort_result", 64'(RESULT), 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);

        // Back-to-back restart with LOAD held high.
        LOAD = 1'b1; A = 16'd2; B = 16'd3;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        check("b2b_done1", 64'(DONE), 64'd1);
        check("b2b_result1", 64'(RESULT), 64'd6);
        A = 16'd4; B = 16'd1;
        @(negedge CLK);
        LOAD = 1'b0;
        check("b2b_no_gap", 64'(BUSY), 64'd1);
        @(negedge CLK);
        check("b2b_done2", 64'(DONE), 64'd1);
        check("b2b_result2", 64'(RESULT), 64'd4);
        @(negedge CLK);

`ifdef MUL_SIGNED_EN
        run_op(16'hFFFD, 16'h0005, 1'b1, "s_neg_pos");
        run_op(16'h8000, 16'h8000, 1'b1, "s_minmin");
        run_op(16'hFFFF, 16'h0000, 1'b1, "s_zero");
        run_op(16'h0000, 16'hFFFF, 1'b1, "s_zero_neg");
        run_op(16'hFFFD, 16'h0005, 1'b0, "s_unsigned");
`endif

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom & ((32'd1 << $urandom_range(0, 16)) - 32'd1);
`ifdef MUL_SIGNED_EN
            rsgn = 1'($urandom_range(0, 1));
`else
            rsgn = 1'b0;
`endif
            run_op(ra[W-1:0], rb[W-1:0], rsgn, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mul_param.md
Name: seq_mul_param

Overview:
Parametrised sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH. It is the next generation of the team's fixed 16-bit multiplier datapath.
- Adds an explicit IDLE/RUN/DONE state machine, a BUSY/DONE handshake and a held result register.
- Terminates early once the remaining multiplier bits are zero.
- Sits between the operand registers and the ALU writeback as a multi-cycle functional unit.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH; must be >= 2.
CNT_W, $clog2(WIDTH+1), width of the internal step counter; derived, not overridden.

Ports:
CLK  in  1  single clock; all state updates on the rising edge.
RESET  in  1  synchronous, active-high reset.
LOAD  in  1  start request; sampled every cycle, accepted only in IDLE or DONE.
A  in  WIDTH  multiplicand; sampled only on an accepted LOAD.
B  in  WIDTH  multiplier; sampled only on an accepted LOAD.
BUSY  out  1  high while in RUN.
DONE  out  1  one-cycle pulse; RESULT is valid from this cycle.
RESULT  out  2*WIDTH  product of the last completed operation, held until the next completion.
P  out  WIDTH  equals RESULT[WIDTH-1:0].

Behaviour:
- Reset: RESET=1 at a clock edge forces state=IDLE, BUSY=0, DONE=0, RESULT=0 and clears all internal registers. Reset overrides LOAD and aborts any operation in RUN; no DONE pulse follows.
- Internal registers: MC (2*WIDTH, multiplicand), MP (WIDTH, multiplier), ACC (2*WIDTH, partial sum), CNT (CNT_W).
- Accepted LOAD: MC <= zero-extended A, MP <= B, ACC <= 0, CNT <= 0.
  - Next state is RUN if B != 0.
  - Next state is DONE if B == 0; RESULT <= 0 and DONE is high in the following cycle.
- RUN step, once per cycle:
  - ACC <= ACC + (MP[0] ? MC : 0), mod 2^(2*WIDTH); no overflow is possible.
  - MC <= MC << 1; MP <= MP >> 1 (zero fill); CNT <= CNT+1.
- RUN exit: leave RUN when the shifted MP is zero or CNT+1 == WIDTH. On exit, RESULT <= the updated ACC value and state -> DONE.
- Latency: with k = (index of the highest set bit of B)+1, and LOAD accepted at edge E0, DONE is high in the cycle after edge E0+k.
  - B=0 gives k=0; the maximum is k=WIDTH.
  - BUSY is high for exactly k cycles.
- DONE state: lasts one cycle, DONE=1, BUSY=0. Next state is IDLE, or the LOAD branch if LOAD=1 (back-to-back restart with no bubble).
- LOAD while in RUN: ignored; operands are not resampled and the in-flight result is unaffected.
- A and B may change freely outside the LOAD acceptance cycle.
- RESULT/P change only at the RUN exit (or on a B=0 accept) and on RESET.

Optional Feature:
Macro MUL_SIGNED_EN.
- Defined:
  - Adds input port SIGNED_OP (1 bit), sampled on accepted LOAD. When SIGNED_OP=1, A and B are treated as two's complement.
  - On LOAD, MC and MP get the magnitudes |A| and |B|. A sign flag latches A[WIDTH-1]^B[WIDTH-1].
  - At RUN exit, RESULT <= sign ? -ACC : ACC.
  - The most-negative operand's magnitude, 2^(WIDTH-1), fits unsigned in WIDTH bits. Latency follows |B|.
  - A zero product is never negated to a nonzero value.
  - When SIGNED_OP=0, behaviour is identical to the undefined build.
- Undefined: no SIGNED_OP port; unsigned only.

Test Plan:
1. WIDTH=16, A=0x0003, B=0x0005, LOAD one cycle -> BUSY high 3 cycles, DONE pulse one cycle later, RESULT=0x0000000F, P=0x000F; RESULT holds for 10 idle cycles.
2. WIDTH=16, A=0xFFFF, B=0xFFFF -> BUSY 16 cycles, RESULT=0xFFFE0001, P=0x0001; repeat with WIDTH=8, A=0xFF, B=0xFF -> 8 cycles, RESULT=0xFE01.
3. A=0x1234, B=0x0000 -> BUSY never high, DONE in the cycle after LOAD, RESULT=0; then A=0x1234, B=0x8000 -> 16 cycles, RESULT=0x091A0000.
4. Start A=7, B=9; during RUN drive LOAD=1 with A=2, B=2 -> ignored, RESULT=63. Start A=5, B=0xF0F0, assert RESET in RUN cycle 4 -> next cycle BUSY=0, DONE=0, RESULT=0, no later DONE.
5. LOAD held high continuously with A=2, B=3, then A=4, B=1 presented in the DONE cycle -> first RESULT=6, second accepted in the DONE cycle, RESULT=4 after 1 BUSY cycle; no idle gap.
6. MUL_SIGNED_EN, SIGNED_OP=1: A=0xFFFD, B=0x0005 -> RESULT=0xFFFFFFF1; A=0x8000, B=0x8000 -> 0x40000000; A=0xFFFF, B=0 -> 0x00000000; SIGNED_OP=0, A=0xFFFD, B=5 -> 0x0004FFF1.
